// File: rtl/pipe_chain.sv
// pipe_chain: elastic chain of STAGES pipeline registers, WIDTH bits each.
// Stage 0 is the youngest entry. Stage STAGES-1 is the oldest and drives the
// output.
//
// Handshake semantics:
//   input side:  a word transfers on a rising edge where in_valid & in_ready.
//   output side: a word transfers on a rising edge where out_valid & out_ready.
//   Neither side's valid may depend combinationally on its own ready.
//   in_ready depends on out_ready, stall_vec and flush_vec.
//
// A stage holds only when it is valid and either it is stalled or the stage
// ahead of it holds. Because an empty stage never holds, bubbles collapse
// automatically. Flushing stage i also kills every younger stage.
module pipe_chain #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall_vec,
    input  logic [STAGES-1:0]       flush_vec,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic [CW-1:0]           occupancy,
    output logic [7:0]              kill_count
);

    localparam int L = STAGES - 1;

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [7:0]                   kill_count_q, kill_count_d;

    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] hold;
    logic              kill_acc;
    logic              hold_acc;
    logic              accept;
    int                kill_sum;
    int                kill_total;

    // Kill and hold terms are swept from the oldest stage toward the youngest.
    always_comb begin
        kill     = '0;
        hold     = '0;
        kill_acc = 1'b0;
        hold_acc = ~out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            kill_acc = kill_acc | flush_vec[i];
            hold_acc = valid_q[i] & (stall_vec[i] | hold_acc);
            kill[i]  = kill_acc;
            hold[i]  = hold_acc;
        end
    end

    // Handshake outputs for both ends of the chain.
    always_comb begin
        in_ready  = ~hold[0] & ~(|flush_vec);
        out_valid = valid_q[L] & ~stall_vec[L] & ~flush_vec[L];
        out_data  = data_q[L];
        accept    = in_valid & in_ready;
    end

    // Per-stage next state. The priority order is kill, then hold, then advance.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill[0]) begin
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                data_d[0] = in_data;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (kill[i]) begin
                valid_d[i] = 1'b0;
            end else if (!hold[i]) begin
                valid_d[i] = valid_q[i-1] & ~hold[i-1];
                if (valid_q[i-1] && !hold[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    // Saturating count of valid entries discarded by flushes.
    always_comb begin
        kill_sum = 0;
        for (int j = 0; j < STAGES; j++) begin
            if (kill[j] && valid_q[j]) begin
                kill_sum = kill_sum + 1;
            end
        end
        kill_total = int'(kill_count_q) + kill_sum;
        if (kill_total > 255) begin
            kill_count_d = 8'd255;
        end else begin
            kill_count_d = 8'(kill_total);
        end
    end

    // Occupancy is the population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + CW'(valid_q[i]);
        end
    end

    // Status outputs taken directly from the registers.
    always_comb begin
        stage_valid = valid_q;
        stage_data  = data_q;
        kill_count  = kill_count_q;
    end

    // Stage registers and kill counter, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            kill_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            kill_count_q <= kill_count_d;
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Directed testbench for pipe_chain with STAGES=4 and WIDTH=16.
// Inputs are driven 2 time units after each rising edge.
// Checks are made 1 time unit later, well away from the next edge.
module tb_pipe_chain;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int CW     = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    in_ready;
    logic [STAGES-1:0]       stall_vec;
    logic [STAGES-1:0]       flush_vec;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic                    out_ready;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic [CW-1:0]           occupancy;
    logic [7:0]              kill_count;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Mid-stall reference tables, one entry per cycle S0..S6.
    logic [STAGES-1:0] ms_stall [7];
    logic [STAGES-1:0] ms_valid [7];
    logic              ms_ovalid[7];
    logic              ms_iready[7];

    pipe_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .stall_vec  (stall_vec),
        .flush_vec  (flush_vec),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .occupancy  (occupancy),
        .kill_count (kill_count)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Stimulus and checks.
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        stall_vec = '0;
        flush_vec = '0;
        out_ready = 1'b1;

        // Reset state.
        #3;
        cyc();
        check("rst_stage_valid", 64'(stage_valid), 64'h0);
        check("rst_stage_data", stage_data, 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_occupancy", 64'(occupancy), 64'h0);
        check("rst_kill_count", 64'(kill_count), 64'h0);
        rst = 1'b0;

        // Fill and drain: 1111..4444 on consecutive cycles with out_ready high.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h1111 * 16'(k + 1);
            settle();
            check("fill_in_ready", 64'(in_ready), 64'h1);
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("drain_out_valid", 64'(out_valid), 64'h1);
            check("drain_out_data", 64'(out_data), 64'(16'h1111 * 16'(k + 1)));
            check("drain_occupancy", 64'(occupancy), 64'(4 - k));
            cyc();
        end
        settle();
        check("drain_empty_valid", 64'(out_valid), 64'h0);
        check("drain_empty_occ", 64'(occupancy), 64'h0);

        // Back-pressure: out_ready low for 10 cycles with continuous input.
        // Only C000..C003 fit into the chain.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hC000 + 16'(k);
            cyc();
        end
        in_valid = 1'b0;
        settle();
        check("bp_occupancy", 64'(occupancy), 64'h4);
        check("bp_in_ready", 64'(in_ready), 64'h0);
        check("bp_stage_data", stage_data, 64'hC000_C001_C002_C003);

        // Mid stall on stage 1 for two cycles, with out_ready released.
        ms_stall  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ms_valid  = '{4'b1111, 4'b1011, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
        ms_ovalid = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ms_iready = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_q = '{16'hC000, 16'hC001, 16'hC002, 16'hC003};
        out_ready = 1'b1;
        for (int s = 0; s < 7; s++) begin
            stall_vec = ms_stall[s];
            in_valid  = (s < 2);
            in_data   = 16'hDEAD;
            settle();
            check($sformatf("ms_stage_valid_s%0d", s), 64'(stage_valid), 64'(ms_valid[s]));
            check($sformatf("ms_out_valid_s%0d", s), 64'(out_valid), 64'(ms_ovalid[s]));
            check($sformatf("ms_in_ready_s%0d", s), 64'(in_ready), 64'(ms_iready[s]));
            if (ms_ovalid[s]) begin
                check($sformatf("ms_out_data_s%0d", s), 64'(out_data), 64'(exp_q.pop_front()));
            end
            if (s == 1) begin
                check("ms_frozen_s1_s0", 64'(stage_data[31:0]), 64'hC002_C003);
            end
            cyc();
        end
        stall_vec = '0;
        in_valid  = 1'b0;

        // Bubble collapse: build {B001, B002, bubble, B003} with out_ready low.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = (k != 2);
            in_data  = (k == 3) ? 16'hB003 : 16'hB001 + 16'(k);
            cyc();
        end
        in_valid = 1'b1;
        in_data  = 16'hB004;
        settle();
        check("bc_stage_valid", 64'(stage_valid), 64'hD);
        check("bc_in_ready", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        settle();
        check("bc_after_valid", 64'(stage_valid), 64'hF);
        check("bc_after_data", stage_data, 64'hB001_B002_B003_B004);
        check("bc_full_in_ready", 64'(in_ready), 64'h0);

        // Flush of stage 2 with input offered: stages 0-2 die and stage 3 holds.
        flush_vec = 4'b0100;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        settle();
        check("fl_in_ready", 64'(in_ready), 64'h0);
        check("fl_out_valid", 64'(out_valid), 64'h1);
        cyc();
        flush_vec = '0;
        in_valid  = 1'b0;
        settle();
        check("fl_stage_valid", 64'(stage_valid), 64'h8);
        check("fl_kill_count", 64'(kill_count), 64'h3);
        check("fl_occupancy", 64'(occupancy), 64'h1);
        check("fl_data_kept", stage_data, 64'hB001_B002_B003_B004);
        out_ready = 1'b1;
        settle();
        check("fl_out_data", 64'(out_data), 64'hB001);
        cyc();
        settle();
        check("fl_drained", 64'(occupancy), 64'h0);

        // Kill counter saturation.
        // 63 full-chain flushes of stage 3 add 252 kills, bringing the count to 255.
        for (int it = 0; it < 64; it++) begin
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1;
                in_data  = 16'(it * 4 + k);
                cyc();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            flush_vec = 4'b1000;
            settle();
            if (it == 0) begin
                check("sat_flush_out_valid", 64'(out_valid), 64'h0);
                check("sat_flush_in_ready", 64'(in_ready), 64'h0);
            end
            cyc();
            flush_vec = '0;
            settle();
            if (it == 62) begin
                check("sat_kill_255", 64'(kill_count), 64'd255);
            end
            if (it == 63) begin
                check("sat_kill_hold", 64'(kill_count), 64'd255);
                check("sat_empty", 64'(stage_valid), 64'h0);
            end
        end

        // Async reset mid-stream, asserted between edges.
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hE001 + 16'(k);
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("ar_stage_valid", 64'(stage_valid), 64'h0);
        check("ar_out_valid", 64'(out_valid), 64'h0);
        check("ar_kill_count", 64'(kill_count), 64'h0);
        check("ar_occupancy", 64'(occupancy), 64'h0);
        rst = 1'b0;
        #1;
        in_valid = 1'b1;
        in_data  = 16'hF001;
        cyc();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            settle();
            check($sformatf("ar_latency_c%0d", k), 64'(out_valid), 64'h0);
            cyc();
        end
        settle();
        check("ar_first_valid", 64'(out_valid), 64'h1);
        check("ar_first_data", 64'(out_data), 64'hF001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
